tx_arbiter: RTL and testbench
=============================

# tx_arbiter

Sequential transmit scheduler that shares the single inter-device transmit port between the three NoC transmit sources: ack queue, waiting-ack (retransmit) queue and forwarded-flit queue. It replaces the combinational buffer selector between those queues and `interdevice_controller`. It arbitrates at packet granularity, never interleaves flits of different packets, and bounds starvation. A one-deep output register decouples source timing from the transmit port.

## Interface
- `STARVE_LIMIT`, default 8: number of packet-start grants a valid requester may lose before it is forced to win; must be ≥1.
- `nocclk` in, 1: clock, rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `ack_flit` in, `types::flit_t`: requester 0 flit.
- `ack_flit_valid` in, 1: requester 0 valid.
- `ack_flit_ready` out, 1: requester 0 ready.
- `waiting_ack_buffer` in, `types::flit_t`: requester 1 (retransmit) flit.
- `waiting_ack_buffer_valid` in, 1: requester 1 valid.
- `waiting_ack_buffer_ready` out, 1: requester 1 ready.
- `forwarded_flit` in, `types::flit_t`: requester 2 flit.
- `forwarded_flit_valid` in, 1: requester 2 valid.
- `forwarded_flit_ready` out, 1: requester 2 ready.
- `flit_out` out, `types::flit_t`: registered flit toward `interdevice_controller`.
- `flit_out_valid` out, 1: `flit_out` holds a flit.
- `flit_out_ready` in, 1: the transmit port accepts `flit_out`.
- `owner` out, 2: current grant owner, 0/1/2; 3 means none.
- `locked` out, 1: a packet is in flight (state LOCK).

## Operation
- Transfer on any port happens when valid and ready are both high at a `nocclk` rising edge.
- Upstream rule: once valid is asserted, the source holds valid and flit stable until accepted.
- Tail detection uses `types::is_tail(flit)`, true for TAIL and HEADTAIL flits. Ack flits are always HEADTAIL.
- The FSM has two states.
  - IDLE: selects a winner combinationally each cycle. If accepting a non-tail flit, the next state is LOCK with `owner` set to that winner. If accepting a tail flit, the FSM stays in IDLE.
  - LOCK: only `owner` can be granted. Accepting a tail flit from `owner` returns the FSM to IDLE. If the owner drops valid, the port idles (bubble) and the lock is held.
- Winner selection in IDLE, first match wins:
  - (a) the lowest-index valid requester whose starve counter equals `STARVE_LIMIT`;
  - (b) requester 0 if valid;
  - (c) round-robin between requesters 1 and 2. Pointer `rr_last` records the last of {1,2} granted a packet start; the other one is preferred.
- Ready: `x_ready = grant[x] && (!flit_out_valid || flit_out_ready)`. At most one ready is high per cycle.
- Starve counters, one per requester, width `$clog2(STARVE_LIMIT+1)`:
  - On each packet-start accept (accept in IDLE), every other requester that is valid increments, saturating at `STARVE_LIMIT`.
  - The granted requester's counter clears to 0.
- `rr_last` updates only on packet-start accepts from requester 1 or 2.
- Output register:
  - Loads on any accept and sets `flit_out_valid`.
  - Clears `flit_out_valid` when `flit_out_ready` is high and no accept occurs that cycle.
  - Simultaneous drain and accept gives back-to-back flits with no bubble.

## Timing
- Latency: a flit accepted at edge N appears on `flit_out` with `flit_out_valid` after edge N. Throughput is 1 flit/cycle while `flit_out_ready` is held high.
- Reset values: `flit_out_valid`=0, `flit_out`=0, all readies=0 (combinational, because grant is none), `owner`=3, `locked`=0, FSM=IDLE, starve counters=0, `rr_last`=2 (so requester 1 is preferred first).
- Assertion of `rst_n` mid-packet drops the lock and output flit immediately. No tail is synthesized; the source queues share `rst_n` and clear too.
- When no requester is valid in IDLE, `owner`=3.
- In LOCK, `owner` holds its value even while its valid is low.
- Full output register with `flit_out_ready` low: all readies are low and the state is frozen.

## Structure
- `types` package: `flit_t`, flit type enum {HEAD, BODY, TAIL, HEADTAIL}, function `is_tail`, and `localparam OWNER_NONE = 2'd3`.
- FSM, counters and output register are all in this module.
- One natural sub-module: `rr_pick2`, the two-way round-robin picker (inputs `req1`, `req2`, `rr_last`; output pick).
- Instantiated in `noc` in place of `tx_buffer_selector_comb`, with identical source port names.

## Test plan
- Reset release with all valids low: `owner`=3, all readies 0, `flit_out_valid`=0. Pulse `rst_n` low while in LOCK: `locked` goes to 0 immediately.
- Ack priority: ack, retransmit and forward valid together, each HEADTAIL, `flit_out_ready`=1. Output order is ack at cycle 1, then retransmit, then forward.
- Packet lock: forward sends HEAD, BODY, TAIL while ack becomes valid after HEAD. `flit_out` shows HEAD, BODY, TAIL contiguously, then the ack. `locked`=1 for exactly 2 cycles.
- Bubble in lock: retransmit drops valid for 3 cycles mid-packet while forward is valid. `forwarded_flit_ready` stays 0 and `flit_out_valid` is 0 for 3 cycles.
- Round-robin and starvation with `STARVE_LIMIT`=2:
  - Ack valid continuously with single flits, plus forward valid.
  - Forward wins on the third packet-start arbitration.
  - With requesters 1 and 2 constantly valid (no ack), grants alternate 1, 2, 1, 2.
- Backpressure: `flit_out_ready`=0 for 5 cycles with a flit held. `flit_out` is stable and all readies are 0. Releasing gives back-to-back drain with no bubble.

Source files
------------

// File: rtl/tx_arbiter_pkg.sv
// Shared flit types for the inter-device transmit path: flit layout, flit kind
// and the arbiter's "no owner" encoding.
package types;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_type_e;

    localparam int FLIT_PAYLOAD_W = 30;

    typedef struct packed {
        flit_type_e                ftype;
        logic [FLIT_PAYLOAD_W-1:0] payload;
    } flit_t;

    localparam logic [1:0] OWNER_NONE = 2'd3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } arb_state_e;

    function automatic logic is_tail(input flit_t f);
        return (f.ftype == TAIL) || (f.ftype == HEADTAIL);
    endfunction

endpackage

// File: rtl/tx_arbiter_rr_pick2.sv
// Two-way round-robin picker between requesters 1 and 2; prefers the one that
// did not win the previous packet start. Returns OWNER_NONE when neither asks.
module rr_pick2
    import types::*;
(
    input  logic       req1,
    input  logic       req2,
    input  logic [1:0] rr_last,
    output logic [1:0] pick
);

    always_comb begin
        pick = OWNER_NONE;
        if (req1 && req2) begin
            pick = (rr_last == 2'd1) ? 2'd2 : 2'd1;
        end else if (req1) begin
            pick = 2'd1;
        end else if (req2) begin
            pick = 2'd2;
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Packet-granular transmit scheduler for the ack, retransmit and forward
// queues, with bounded starvation and a one-deep registered output.
module tx_arbiter
    import types::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic  nocclk,
    input  logic  rst_n,
    input  flit_t ack_flit,
    input  logic  ack_flit_valid,
    output logic  ack_flit_ready,
    input  flit_t waiting_ack_buffer,
    input  logic  waiting_ack_buffer_valid,
    output logic  waiting_ack_buffer_ready,
    input  flit_t forwarded_flit,
    input  logic  forwarded_flit_valid,
    output logic  forwarded_flit_ready,
    output flit_t flit_out,
    output logic  flit_out_valid,
    input  logic  flit_out_ready,
    output logic [1:0] owner,
    output logic  locked
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

    arb_state_e           state_q, state_d;
    logic [1:0]           owner_q, owner_d;
    logic [1:0]           rr_last_q, rr_last_d;
    logic [2:0][CW-1:0]   starve_q, starve_d;
    flit_t                flit_out_q, flit_out_d;
    logic                 fov_q, fov_d;

    logic [2:0]           req;
    flit_t                src_flit [3];
    logic [1:0]           rr_pick;
    logic [1:0]           idle_winner;
    logic [1:0]           cur_owner;
    logic [2:0]           ready;
    logic                 space;
    logic                 accept;
    flit_t                sel_flit;

    assign req         = {forwarded_flit_valid, waiting_ack_buffer_valid, ack_flit_valid};
    assign src_flit[0] = ack_flit;
    assign src_flit[1] = waiting_ack_buffer;
    assign src_flit[2] = forwarded_flit;

    rr_pick2 u_rr_pick2 (
        .req1    (req[1]),
        .req2    (req[2]),
        .rr_last (rr_last_q),
        .pick    (rr_pick)
    );

    // Starved requesters first (lowest index), then ack, then round-robin 1/2.
    always_comb begin
        idle_winner = OWNER_NONE;
        if (req[0]) begin
            idle_winner = 2'd0;
        end else begin
            idle_winner = rr_pick;
        end
        for (int i = 2; i >= 0; i--) begin
            if (req[i] && (starve_q[i] == LIMIT_C)) begin
                idle_winner = 2'(i);
            end
        end
    end

    assign cur_owner = (state_q == S_LOCK) ? owner_q : idle_winner;
    assign space     = !fov_q || flit_out_ready;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            ready[i] = (cur_owner == 2'(i)) && space;
        end
    end

    assign accept = |(ready & req);

    always_comb begin
        case (cur_owner)
            2'd0:    sel_flit = src_flit[0];
            2'd1:    sel_flit = src_flit[1];
            2'd2:    sel_flit = src_flit[2];
            default: sel_flit = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_last_d  = rr_last_q;
        starve_d   = starve_q;
        flit_out_d = flit_out_q;
        fov_d      = fov_q;

        if (accept) begin
            flit_out_d = sel_flit;
            fov_d      = 1'b1;
            if (state_q == S_IDLE) begin
                if (!is_tail(sel_flit)) begin
                    state_d = S_LOCK;
                    owner_d = cur_owner;
                end
                if (cur_owner != 2'd0) begin
                    rr_last_d = cur_owner;
                end
                for (int i = 0; i < 3; i++) begin
                    if (cur_owner == 2'(i)) begin
                        starve_d[i] = '0;
                    end else if (req[i] && (starve_q[i] != LIMIT_C)) begin
                        starve_d[i] = starve_q[i] + CW'(1);
                    end
                end
            end else if (is_tail(sel_flit)) begin
                state_d = S_IDLE;
                owner_d = OWNER_NONE;
            end
        end else if (flit_out_ready) begin
            fov_d = 1'b0;
        end
    end

    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            owner_q    <= OWNER_NONE;
            rr_last_q  <= 2'd2;
            starve_q   <= '0;
            flit_out_q <= '0;
            fov_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_last_q  <= rr_last_d;
            starve_q   <= starve_d;
            flit_out_q <= flit_out_d;
            fov_q      <= fov_d;
        end
    end

    assign ack_flit_ready           = ready[0];
    assign waiting_ack_buffer_ready = ready[1];
    assign forwarded_flit_ready     = ready[2];
    assign flit_out                 = flit_out_q;
    assign flit_out_valid           = fov_q;
    assign owner                    = cur_owner;
    assign locked                   = (state_q == S_LOCK);

endmodule

// File: tb/tb_tx_arbiter.sv
// Randomised bench for tx_arbiter: packet-generating sources obeying the
// hold-until-accepted rule, checked each cycle against a rule-level model.
module tb_tx_arbiter;
    import types::*;

    localparam int LIMIT = 2;

    logic  nocclk = 1'b0;
    logic  rst_n  = 1'b0;
    flit_t in_flit [3];
    logic  in_vld  [3];
    logic  ack_rdy, wa_rdy, fwd_rdy;
    flit_t flit_out;
    logic  flit_out_valid;
    logic  flit_out_ready = 1'b0;
    logic [1:0] owner;
    logic  locked;

    int n_cmp = 0;
    int n_err = 0;

    bit    m_locked;
    int    m_owner;
    int    m_starve [3];
    int    m_rr;
    bit    m_ov;
    flit_t m_out;

    int s_len [3];
    int s_pos [3];
    int s_seq [3];
    int prob  [3];
    int rdy_prob;
    bit pend_acc;
    int pend_own;

    always #5 nocclk = ~nocclk;

    tx_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .nocclk                   (nocclk),
        .rst_n                    (rst_n),
        .ack_flit                 (in_flit[0]),
        .ack_flit_valid           (in_vld[0]),
        .ack_flit_ready           (ack_rdy),
        .waiting_ack_buffer       (in_flit[1]),
        .waiting_ack_buffer_valid (in_vld[1]),
        .waiting_ack_buffer_ready (wa_rdy),
        .forwarded_flit           (in_flit[2]),
        .forwarded_flit_valid     (in_vld[2]),
        .forwarded_flit_ready     (fwd_rdy),
        .flit_out                 (flit_out),
        .flit_out_valid           (flit_out_valid),
        .flit_out_ready           (flit_out_ready),
        .owner                    (owner),
        .locked                   (locked)
    );

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int new_len(input int i);
        return (i == 0) ? 1 : int'($urandom_range(1, 4));
    endfunction

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = 3;
        m_rr     = 2;
        m_ov     = 1'b0;
        m_out    = '0;
        pend_acc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_starve[i] = 0;
            in_vld[i]   = 1'b0;
            in_flit[i]  = '0;
            s_pos[i]    = 0;
            s_len[i]    = new_len(i);
        end
    endtask

    task automatic present(input int i);
        flit_t f;
        if (s_len[i] == 1)               f.ftype = HEADTAIL;
        else if (s_pos[i] == 0)          f.ftype = HEAD;
        else if (s_pos[i] == s_len[i]-1) f.ftype = TAIL;
        else                             f.ftype = BODY;
        f.payload  = {2'(i), 12'(s_seq[i]), 16'(s_pos[i])};
        in_flit[i] = f;
        in_vld[i]  = 1'b1;
    endtask

    task automatic step();
        int own;
        bit space, acc;
        logic [2:0] exp_rdy;
        @(negedge nocclk);
        if (pend_acc) begin
            in_vld[pend_own] = 1'b0;
            s_pos[pend_own]++;
            if (s_pos[pend_own] == s_len[pend_own]) begin
                s_pos[pend_own] = 0;
                s_len[pend_own] = new_len(pend_own);
                s_seq[pend_own]++;
            end
            pend_acc = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            if (!in_vld[i] && (int'($urandom_range(0, 99)) < prob[i])) present(i);
        end
        flit_out_ready = (int'($urandom_range(0, 99)) < rdy_prob);
        #1;
        if (m_locked) begin
            own = m_owner;
        end else begin
            own = 3;
            for (int i = 0; i < 3; i++)
                if (own == 3 && in_vld[i] && m_starve[i] == LIMIT) own = i;
            if (own == 3 && in_vld[0]) own = 0;
            if (own == 3) begin
                if (in_vld[1] && in_vld[2]) own = (m_rr == 1) ? 2 : 1;
                else if (in_vld[1])         own = 1;
                else if (in_vld[2])         own = 2;
            end
        end
        space = !m_ov || flit_out_ready;
        exp_rdy = '0;
        if (own != 3 && space) exp_rdy[own] = 1'b1;
        acc = (own != 3) && in_vld[own] && space;

        chk_eq("owner",    64'(owner), 64'(own));
        chk_eq("locked",   64'(locked), 64'(m_locked));
        chk_eq("ready",    64'({fwd_rdy, wa_rdy, ack_rdy}), 64'(exp_rdy));
        chk_eq("out_vld",  64'(flit_out_valid), 64'(m_ov));
        chk_eq("flit_out", 64'(flit_out), 64'(m_out));

        if (acc) begin
            if (!m_locked) begin
                for (int j = 0; j < 3; j++) begin
                    if (j == own) m_starve[j] = 0;
                    else if (in_vld[j] && m_starve[j] < LIMIT) m_starve[j]++;
                end
                if (own != 0) m_rr = own;
                if (!is_tail(in_flit[own])) begin
                    m_locked = 1'b1;
                    m_owner  = own;
                end
            end else if (is_tail(in_flit[own])) begin
                m_locked = 1'b0;
                m_owner  = 3;
            end
            m_out    = in_flit[own];
            m_ov     = 1'b1;
            pend_acc = 1'b1;
            pend_own = own;
        end else if (flit_out_ready) begin
            m_ov = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge nocclk);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_eq("rst_locked",   64'(locked), 64'd0);
        chk_eq("rst_owner",    64'(owner), 64'd3);
        chk_eq("rst_ready",    64'({fwd_rdy, wa_rdy, ack_rdy}), 64'd0);
        chk_eq("rst_out_vld",  64'(flit_out_valid), 64'd0);
        chk_eq("rst_flit_out", 64'(flit_out), 64'd0);
        @(negedge nocclk);
        rst_n = 1'b1;
    endtask

    task automatic run_phase(input int p0, input int p1, input int p2, input int pr, input int cycles);
        prob[0]  = p0;
        prob[1]  = p1;
        prob[2]  = p2;
        rdy_prob = pr;
        repeat (cycles) step();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) s_seq[i] = 0;
        prob[0] = 0; prob[1] = 0; prob[2] = 0;
        rdy_prob = 100;
        model_reset();
        do_reset();
        run_phase(0, 0, 0, 100, 3);

        run_phase(70, 70, 70, 100, 300);
        do_reset();
        run_phase(100, 0, 100, 100, 100);
        do_reset();
        run_phase(0, 100, 100, 100, 100);
        do_reset();
        run_phase(60, 60, 60, 30, 400);
        do_reset();
        run_phase(50, 40, 80, 80, 400);

        prob[0] = 0; prob[1] = 100; prob[2] = 100; rdy_prob = 100;
        begin
            int budget = 200;
            while (!m_locked && budget > 0) begin
                step();
                budget--;
            end
            chk_eq("lock_reached", 64'(m_locked), 64'd1);
        end
        do_reset();
        run_phase(0, 0, 0, 100, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
